// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Requester ids, the command record and the default bus widths.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef logic req_id_t;
  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic cmd_t make_cmd(input logic we,
                                    input logic [DEF_ADDR_W-1:0] addr,
                                    input logic [DEF_DATA_W-1:0] wdata);
    cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
// Purely combinational; the last-winner register lives in the caller.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    grant  = 2'b00;
    winner = REQ0;
    case (eligible)
      2'b01: begin
        grant  = 2'b01;
        winner = REQ0;
      end
      2'b10: begin
        grant  = 2'b10;
        winner = REQ1;
      end
      2'b11: begin
        if (last_gnt == REQ1) begin
          grant  = 2'b01;
          winner = REQ0;
        end else begin
          grant  = 2'b10;
          winner = REQ1;
        end
      end
      default: begin
        grant  = 2'b00;
        winner = REQ0;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one synchronous 1-cycle-latency RAM between two requesters with round-robin
// arbitration, a registered command bus and a one-stage read tag for data steering.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0] eligible_p0;
  logic [1:0] grant_p0;
  logic       winner_p0;
  logic       issue_p0;
  logic       last_gnt;
  cmd_t       cmd_p0;

  logic       tag_vld_p1;
  req_id_t    tag_id_p1;

  // Stage p0: pick a winner; a requester whose grant is currently visible is masked
  assign eligible_p0 = {req1 & ~gnt1, req0 & ~gnt0};
  assign issue_p0    = |grant_p0;

  rr_arb2 u_rr (
    .eligible (eligible_p0),
    .last_gnt (last_gnt),
    .grant    (grant_p0),
    .winner   (winner_p0)
  );

  always_comb begin
    if (winner_p0 == REQ1) cmd_p0 = make_cmd(we1, addr1, wdata1);
    else                   cmd_p0 = make_cmd(we0, addr0, wdata0);
  end

  // Stage p1: command on the RAM bus, tag of an issued read; p2: tag becomes rvalid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      last_gnt   <= REQ1;
      tag_vld_p1 <= 1'b0;
      tag_id_p1  <= REQ0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      gnt0       <= grant_p0[0];
      gnt1       <= grant_p0[1];
      ram_we     <= issue_p0 & cmd_p0.we;
      ram_re     <= issue_p0 & ~cmd_p0.we;
      if (issue_p0) begin
        ram_addr <= cmd_p0.addr;
        last_gnt <= winner_p0;
        if (cmd_p0.we) ram_din <= cmd_p0.wdata;
      end
      tag_vld_p1 <= issue_p0 & ~cmd_p0.we;
      tag_id_p1  <= winner_p0;
      rvalid0    <= tag_vld_p1 & (tag_id_p1 == REQ0);
      rvalid1    <= tag_vld_p1 & (tag_id_p1 == REQ1);
    end
  end

  assign rdata = ram_dout;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed table-driven bench for ram_arbiter_2p with a behavioural 16x8 sync RAM.
module tb_ram_arbiter_2p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       ram_we, ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       init_mem;

  logic [7:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Synchronous RAM, contents preloaded with 0x40+index.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_addr];
    end
  end

  // Requester protocol: a pending, ungranted command must be held stable.
  logic       pend0 = 1'b0, pend1 = 1'b0;
  logic       s_we0, s_we1;
  logic [3:0] s_a0, s_a1;
  logic [7:0] s_d0, s_d1;
  always @(posedge clk) begin
    if (rst_n && pend0 && !gnt0)
      assert (req0 && we0 == s_we0 && addr0 == s_a0 && wdata0 == s_d0)
        else $error("protocol violation on requester 0");
    if (rst_n && pend1 && !gnt1)
      assert (req1 && we1 == s_we1 && addr1 == s_a1 && wdata1 == s_d1)
        else $error("protocol violation on requester 1");
    pend0 <= rst_n && req0 && !gnt0;
    pend1 <= rst_n && req1 && !gnt1;
    s_we0 <= we0; s_a0 <= addr0; s_d0 <= wdata0;
    s_we1 <= we1; s_a1 <= addr1; s_d1 <= wdata1;
  end

  typedef struct {
    logic       rst_n;
    logic       r0, w0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       g0, g1, we, re;
    logic [3:0] addr;
    logic [7:0] din;
    logic       rv0, rv1;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(input int rs,
                              input int r0, input int w0, input int a0, input int d0,
                              input int r1, input int w1, input int a1, input int d1,
                              input int g0, input int g1, input int we, input int re,
                              input int addr, input int din,
                              input int rv0, input int rv1, input int rd);
    vec_t v;
    v.rst_n = 1'(rs);
    v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = 4'(a0); v.d0 = 8'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = 4'(a1); v.d1 = 8'(d1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.we = 1'(we); v.re = 1'(re);
    v.addr = 4'(addr); v.din = 8'(din);
    v.rv0 = 1'(rv0); v.rv1 = 1'(rv1); v.rd = 8'(rd);
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int row);
    rst_n  = v.rst_n;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(posedge clk);
    #1;
    chk("gnt0",     row, 8'(gnt0),     8'(v.g0));
    chk("gnt1",     row, 8'(gnt1),     8'(v.g1));
    chk("ram_we",   row, 8'(ram_we),   8'(v.we));
    chk("ram_re",   row, 8'(ram_re),   8'(v.re));
    chk("ram_addr", row, 8'(ram_addr), 8'(v.addr));
    chk("ram_din",  row, ram_din,      v.din);
    chk("rvalid0",  row, 8'(rvalid0),  8'(v.rv0));
    chk("rvalid1",  row, 8'(rvalid1),  8'(v.rv1));
    if (v.rv0 || v.rv1) chk("rdata", row, rdata, v.rd);
  endtask

  vec_t tbl [32];
  vec_t seq [8];

  initial begin
    // reset with both requesting, then first conflict goes to requester 0
    tbl[0]  = mk(0, 1,0,2,0,     1,0,5,0,  0,0,0,0, 0,0,      0,0,0);
    tbl[1]  = mk(0, 1,0,2,0,     1,0,5,0,  0,0,0,0, 0,0,      0,0,0);
    tbl[2]  = mk(0, 1,0,2,0,     1,0,5,0,  0,0,0,0, 0,0,      0,0,0);
    tbl[3]  = mk(1, 1,0,2,0,     1,0,5,0,  1,0,0,1, 2,0,      0,0,0);
    tbl[4]  = mk(1, 0,0,0,0,     1,0,5,0,  0,1,0,1, 5,0,      1,0,8'h42);
    tbl[5]  = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 5,0,      0,1,8'h45);
    // single write then read of the same word
    tbl[6]  = mk(1, 1,1,3,8'hA5, 0,0,0,0,  1,0,1,0, 3,8'hA5,  0,0,0);
    tbl[7]  = mk(1, 1,0,3,0,     0,0,0,0,  0,0,0,0, 3,8'hA5,  0,0,0);
    tbl[8]  = mk(1, 1,0,3,0,     0,0,0,0,  1,0,0,1, 3,8'hA5,  0,0,0);
    tbl[9]  = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 3,8'hA5,  1,0,8'hA5);
    // held read: grants every other cycle, never twice for one command
    tbl[10] = mk(1, 1,0,9,0,     0,0,0,0,  1,0,0,1, 9,8'hA5,  0,0,0);
    tbl[11] = mk(1, 1,0,9,0,     0,0,0,0,  0,0,0,0, 9,8'hA5,  1,0,8'h49);
    tbl[12] = mk(1, 1,0,9,0,     0,0,0,0,  1,0,0,1, 9,8'hA5,  0,0,0);
    tbl[13] = mk(1, 1,0,9,0,     0,0,0,0,  0,0,0,0, 9,8'hA5,  1,0,8'h49);
    tbl[14] = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 9,8'hA5,  0,0,0);
    tbl[15] = mk(1, 0,0,0,0,     1,0,8,0,  0,1,0,1, 8,8'hA5,  0,0,0);
    tbl[16] = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 8,8'hA5,  0,1,8'h48);
    // read-after-write across requesters
    tbl[17] = mk(1, 1,1,7,8'h3C, 1,0,7,0,  1,0,1,0, 7,8'h3C,  0,0,0);
    tbl[18] = mk(1, 0,0,0,0,     1,0,7,0,  0,1,0,1, 7,8'h3C,  0,0,0);
    tbl[19] = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 7,8'h3C,  0,1,8'h3C);
    // continuous contention: alternating grants, bus busy every cycle
    tbl[20] = mk(1, 1,1,1,8'h11, 1,0,8,0,  1,0,1,0, 1,8'h11,  0,0,0);
    tbl[21] = mk(1, 1,1,2,8'h22, 1,0,8,0,  0,1,0,1, 8,8'h11,  0,0,0);
    tbl[22] = mk(1, 1,1,2,8'h22, 1,0,9,0,  1,0,1,0, 2,8'h22,  0,1,8'h48);
    tbl[23] = mk(1, 1,1,3,8'h33, 1,0,9,0,  0,1,0,1, 9,8'h22,  0,0,0);
    tbl[24] = mk(1, 1,1,3,8'h33, 1,0,10,0, 1,0,1,0, 3,8'h33,  0,1,8'h49);
    tbl[25] = mk(1, 1,1,4,8'h44, 1,0,10,0, 0,1,0,1, 10,8'h33, 0,0,0);
    tbl[26] = mk(1, 1,1,4,8'h44, 1,0,11,0, 1,0,1,0, 4,8'h44,  0,1,8'h4A);
    tbl[27] = mk(1, 0,0,0,0,     1,0,11,0, 0,1,0,1, 11,8'h44, 0,0,0);
    tbl[28] = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 11,8'h44, 0,1,8'h4B);
    tbl[29] = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 11,8'h44, 0,0,0);
    tbl[30] = mk(1, 0,0,0,0,     1,0,1,0,  0,1,0,1, 1,8'h44,  0,0,0);
    tbl[31] = mk(1, 0,0,0,0,     0,0,0,0,  0,0,0,0, 1,8'h44,  0,1,8'h11);

    // reset while a requester-1 read is in its grant cycle
    seq[0] = mk(1, 0,0,0,0, 1,0,5,0, 0,1,0,1, 5,8'h44, 0,0,0);
    seq[1] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,     0,0,0);
    seq[2] = mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,     0,0,0);
    seq[3] = mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,     0,0,0);
    seq[4] = mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,     0,0,0);
    seq[5] = mk(1, 1,0,2,0, 1,0,3,0, 1,0,0,1, 2,0,     0,0,0);
    seq[6] = mk(1, 0,0,0,0, 1,0,3,0, 0,1,0,1, 3,0,     1,0,8'h22);
    seq[7] = mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 3,0,     0,1,8'h33);

    init_mem = 1'b1;
    for (int i = 0; i < 32; i++) begin
      run(tbl[i], i);
      init_mem = 1'b0;
    end
    for (int i = 0; i < 8; i++) run(seq[i], 100 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Mutual exclusion of grants, returns and RAM strobes, checked every cycle.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("gnt_excl",    0, 8'(gnt0 & gnt1),       8'd0);
        chk("rvalid_excl", 0, 8'(rvalid0 & rvalid1), 8'd0);
        chk("strobe_excl", 0, 8'(ram_we & ram_re),   8'd0);
      end
    end
  end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
Shares one 16x8 synchronous RAM (registered read, 1-cycle read latency, read enable and write enable on the same address) between two independent requesters.
- Round-robin arbitration between the two requesters.
- Registers the winning command onto the RAM bus.
- Steers read data back to the requester that issued the read, using a tag pipeline.
- Sits between the RAM and two client blocks (e.g. a host loader and a datapath engine).

Parameters:
ADDR_W, 4, RAM address width (16 words)
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
req0  in  1  requester 0 command valid; held with fields stable until gnt0
we0  in  1  requester 0: 1=write, 0=read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  1-cycle pulse: requester 0 command issued to RAM this cycle
rvalid0  out  1  1-cycle pulse: rdata holds requester 0 read result
req1/we1/addr1/wdata1/gnt1/rvalid1  same as above, requester 1
rdata  out  DATA_W  shared read data, valid only with rvalid0/rvalid1
ram_we  out  1  to RAM we
ram_re  out  1  to RAM re
ram_addr  out  ADDR_W  to RAM addr
ram_din  out  DATA_W  to RAM din
ram_dout  in  DATA_W  from RAM dout

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_re go to 0.
  - ram_addr and ram_din go to 0.
  - The round-robin pointer last_gnt goes to 1, so requester 0 wins the first conflict.
  - The read-tag pipeline is cleared.
  - A read in flight at reset never produces rvalid.
  - The arbiter does not reset RAM contents.
- Arbitration (cycle N, combinational pick, result registered at the end of N):
  - eligible_i = req_i AND NOT gnt_i. A requester is masked in the cycle its grant is visible, so a held req is never issued twice.
  - Only one eligible: it wins.
  - Both eligible: the requester that is not last_gnt wins; last_gnt updates to the winner.
  - Neither eligible: the registered outputs in the next cycle are ram_we=0, ram_re=0, gnt*=0. ram_addr and ram_din hold their previous values.
- Issue (cycle N+1, registered):
  - gnt_w=1 for the winner.
  - ram_addr=addr_w.
  - If we_w=1: ram_we=1, ram_re=0, ram_din=wdata_w.
  - If we_w=0: ram_re=1, ram_we=0.
  - ram_we and ram_re are never both 1.
  - The RAM performs the access at the end of N+1.
- Read return (cycle N+2):
  - rvalid_w=1 (registered from the issue-cycle tag).
  - rdata=ram_dout (passthrough).
  - Read latency from gnt to rvalid is exactly 1 cycle; from first req to rvalid it is 2 cycles.
  - Write produces no response; gnt marks acceptance.
- Requester protocol:
  - Hold req and fields until gnt.
  - In the cycle after gnt, either deassert req or present a new command.
  - A single requester can issue at most every other cycle.
  - With both requesting continuously, grants alternate 0,1,0,1 and the RAM bus issues every cycle.
- Ordering:
  - Commands take effect in grant order.
  - A write granted in cycle G is visible to a read granted in G+1 or later.
  - There is no same-cycle conflict, because only one command is issued per cycle.
- rvalid0 and rvalid1 are never high in the same cycle; gnt0 and gnt1 are never high in the same cycle.
- Changing req or fields before gnt is a protocol violation. Behaviour in that case is undefined (assertion in the bench).

Decomposition:
- Package ram_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - Requester id type (1 bit), with constants REQ0=0 and REQ1=1.
  - Command struct {we, addr, wdata}.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: eligible[1:0], last_gnt.
  - Outputs: grant one-hot, winner id.
  - Purely combinational; the last_gnt register stays in the top.
- The top holds the command register, gnt registers, and the 1-stage read-tag (valid + id) register.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req0=req1=1 -> all outputs 0; after release, the first grant is gnt0 (pointer=1).
2. Single write then read: req0 we0=1 addr0=3 wdata0=0xA5 -> gnt0 next cycle with ram_we=1, ram_addr=3, ram_din=0xA5. Then req0 read addr0=3 -> gnt0, ram_re=1, and the following cycle rvalid0=1, rdata=0xA5, rvalid1=0.
3. Contention: both req held continuously, requester 0 writing addr 1..4, requester 1 reading addr 8..11 -> gnt alternates 0,1,0,1 with no idle bus cycle; each rvalid1 arrives 1 cycle after its gnt1 with the correct preloaded data.
4. Read-after-write across requesters: req0 write addr 7=0x3C and req1 read addr 7 asserted the same cycle with pointer=1 -> write is granted first, then the read; rvalid1 returns 0x3C.
5. No double issue: req0 read held high for 4 cycles with requester 1 idle -> gnt0 pattern 1,0,1,0; exactly one ram_re per gnt0.
6. Reset mid-read: rst_n=0 in the cycle gnt1 (read) is high -> no rvalid1 in any later cycle; the first grant after release goes to requester 0 when both request.
